// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: shared defaults, k-width helper and per-stage control payload
// for the approximate pipelined adder.
package pipe_add_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
  localparam int DEF_APPROX_MAX = DEF_WIDTH;
  function automatic int k_width(input int w);
    return $clog2(w + 1);
  endfunction
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;
endpackage

// File: rtl/pipe_add_approx_add_seg.sv
// add_seg: combinational segment adder; masked bits OR their operands and kill the carry.
module add_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic [SEG-1:0] m,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  logic [SEG:0] c;
  always_comb begin
    c = '0;
    s = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i] = m[i] ? a[i] | b[i] : a[i] ^ b[i] ^ c[i];
      c[i+1] = m[i] ? 1'b0 : (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign co = c[SEG];
endmodule

// File: rtl/pipe_add_approx.sv
// pipe_add_approx: STAGES-deep adder with a lower-part-OR approximation of the
// k least significant bits; one SEG-bit segment is resolved per stage.
module pipe_add_approx
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int APPROX_MAX = WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic [k_width(WIDTH)-1:0] approx_k,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH:0]            sum
);
  localparam int SEG = WIDTH / STAGES;
  localparam int KW = k_width(WIDTH);
  localparam logic [KW-1:0] KMAX = KW'(APPROX_MAX);

  if (WIDTH % STAGES != 0 || APPROX_MAX > WIDTH || APPROX_MAX < 0) begin : g_bad_params
    $error("pipe_add_approx: WIDTH must divide by STAGES and APPROX_MAX must lie in 0..WIDTH");
  end

  stage_ctl_t       ctl_q [STAGES];
  stage_ctl_t       ctl_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [KW-1:0]    k_q [STAGES];
  logic [KW-1:0]    k_d [STAGES];
  logic             adv;
  logic [KW-1:0]    k_eff;

  assign adv = !ctl_q[STAGES-1].valid || out_ready;
  assign in_ready = adv;
  assign out_valid = ctl_q[STAGES-1].valid;
  assign sum = {ctl_q[STAGES-1].carry, s_q[STAGES-1]};
  assign k_eff = approx_k > KMAX ? KMAX : approx_k;

  for (genvar j = 0; j < STAGES; j++) begin : g_st
    logic [WIDTH-1:0] a_i, b_i, s_i;
    logic [KW-1:0]    k_i;
    logic             v_i, c_i, c_o;
    logic [SEG-1:0]   m, s_seg;
    if (j == 0) begin : g_head
      assign a_i = a;
      assign b_i = b;
      assign s_i = '0;
      assign k_i = k_eff;
      assign v_i = in_valid;
      assign c_i = 1'b0;
    end else begin : g_body
      assign a_i = a_q[j-1];
      assign b_i = b_q[j-1];
      assign s_i = s_q[j-1];
      assign k_i = k_q[j-1];
      assign v_i = ctl_q[j-1].valid;
      assign c_i = ctl_q[j-1].carry;
    end
    always_comb begin
      m = '0;
      for (int i = 0; i < SEG; i++) m[i] = (j * SEG + i) < int'(k_i);
    end
    add_seg #(.SEG(SEG)) u_seg (
      .a (a_i[j*SEG +: SEG]),
      .b (b_i[j*SEG +: SEG]),
      .m (m),
      .ci(c_i),
      .s (s_seg),
      .co(c_o)
    );
    assign ctl_d[j] = '{valid: v_i, carry: c_o};
    assign a_d[j] = a_i;
    assign b_d[j] = b_i;
    assign k_d[j] = k_i;
    assign s_d[j] = s_i | (WIDTH'(s_seg) << (j * SEG));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < STAGES; j++) begin
        ctl_q[j] <= '0;
        a_q[j] <= '0;
        b_q[j] <= '0;
        s_q[j] <= '0;
        k_q[j] <= '0;
      end
    end else if (adv) begin
      ctl_q <= ctl_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      k_q <= k_d;
    end
  end
endmodule

// File: tb/tb_pipe_add_approx.sv
// tb_pipe_add_approx: directed and randomized checks of latency, approximation,
// saturation, backpressure and reset flush for the default 16/4 configuration.
module tb_pipe_add_approx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [15:0] a = '0, b = '0;
  logic [4:0]  approx_k = '0;
  logic [16:0] sum;
  int          n_chk = 0, n_err = 0;
  logic [16:0] exp_s [4];
  logic [16:0] q [$];

  pipe_add_approx dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_k(approx_k), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact add of the bits above k, plus OR of the bits below k.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input int k);
    int ke;
    logic [16:0] m;
    ke = k > 16 ? 16 : k;
    m = (17'h1 << ke) - 17'h1;
    return ((({1'b0, x} >> ke) + ({1'b0, y} >> ke)) << ke) | ({1'b0, x | y} & m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [4:0] k, input logic [16:0] exp);
    int lat;
    a = x;
    b = y;
    approx_k = k;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " sum"}, sum, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, sent, got, first, last, stale;
    #3;
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset in_ready", in_ready, 1);
    #4 rst_n = 1'b1;
    tick();
    check("idle in_ready", in_ready, 1);

    run_one("carry out", 16'hFFFF, 16'h0001, 5'd0, 17'h10000);
    run_one("k4", 16'h000F, 16'h0001, 5'd4, 17'h0000F);
    run_one("k0", 16'h000F, 16'h0001, 5'd0, 17'h00010);
    run_one("sat20", 16'h8000, 16'h8000, 5'd20, 17'h08000);
    run_one("k16", 16'hFFFF, 16'hFFFF, 5'd16, 17'h0FFFF);
    run_one("k8", 16'h12FF, 16'h34FF, 5'd8, 17'h046FF);
    run_one("k5 cross seg", 16'h001F, 16'h0021, 5'd5, 17'h0003F);

    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      a = 16'h0F00 + 16'(c);
      b = 16'h00F1;
      approx_k = 5'(c);
      in_valid = 1'b1;
      if (in_ready) begin
        if (acc < 4) exp_s[acc] = model(a, b, c);
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stall accepted", acc, 4);
    check("stall in_ready", in_ready, 0);
    check("stall out_valid", out_valid, 1);
    check("stall sum", sum, exp_s[0]);
    tick();
    tick();
    check("stall sum held", sum, exp_s[0]);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain valid", out_valid, 1);
      check("drain sum", sum, exp_s[i]);
      tick();
    end
    check("drain empty", out_valid, 0);

    sent = 0;
    got = 0;
    first = -1;
    last = -1;
    for (int c = 0; c < 120; c++) begin
      if (sent < 100) begin
        a = 16'($urandom);
        b = 16'($urandom);
        approx_k = 5'($urandom_range(0, 20));
        in_valid = 1'b1;
        q.push_back(model(a, b, int'(approx_k)));
        sent++;
      end else in_valid = 1'b0;
      tick();
      if (out_valid) begin
        if (first < 0) first = c + 1;
        last = c + 1;
        got++;
        if (q.size() == 0) check("rand extra result", 1, 0);
        else check("rand sum", sum, q.pop_front());
      end
    end
    check("rand count", got, 100);
    check("rand first cycle", first, 4);
    check("rand last cycle", last, 103);

    for (int i = 0; i < 4; i++) begin
      a = 16'h1234;
      b = 16'h1111;
      approx_k = 5'd0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pre-reset valid", out_valid, 1);
    check("pre-reset sum", sum, 17'h02345);
    rst_n = 1'b0;
    #1;
    check("async reset valid", out_valid, 0);
    check("async reset sum", sum, 0);
    check("async reset in_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      tick();
      if (out_valid) stale++;
    end
    check("no stale results", stale, 0);
    run_one("post reset", 16'hFFFF, 16'h0001, 5'd0, 17'h10000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_add_approx.md
PIPE_ADD_APPROX -- requirements
Module: pipe_add_approx

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH divisible by STAGES; segment width SEG = WIDTH/STAGES.
REQ-003 SHALL have parameter APPROX_MAX, default WIDTH: largest honoured approximate-LSB count.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: operand tuple offered.
REQ-007 SHALL have port in_ready, output, 1: tuple accepted when in_valid & in_ready at a rising edge.
REQ-008 SHALL have port a, input, WIDTH: unsigned operand A.
REQ-009 SHALL have port b, input, WIDTH: unsigned operand B.
REQ-010 SHALL have port approx_k, input, clog2(WIDTH+1): number of approximate LSBs, sampled with the tuple.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: result consumed when out_valid & out_ready at a rising edge.
REQ-013 SHALL have port sum, output, WIDTH+1: result; MSB is carry-out.

Function
REQ-014 SHALL compute sum = a + b exactly, zero-extended to WIDTH+1, when the effective k is 0.
REQ-015 SHALL set effective k = min(approx_k, APPROX_MAX), saturating without error.
REQ-016 SHALL, for bit positions i < k, produce sum[i] = a[i] | b[i], and inject carry 0 into bit k (lower-part OR).
REQ-017 SHALL ripple-add bits i >= k exactly; with k = WIDTH, sum[WIDTH] = 0.
REQ-018 SHALL process one SEG-bit segment per stage: stage j adds bits [j*SEG +: SEG] with the carry registered from stage j-1; stage 0 carry-in is 0.
REQ-019 SHALL carry the unprocessed upper operand bits, the completed lower sum bits, the effective k and a valid bit along the pipeline registers.
REQ-020 SHALL present a tuple accepted in cycle N on sum/out_valid in cycle N+STAGES, absent stalls.
REQ-021 SHALL sustain one accepted tuple per cycle while out_ready = 1.
REQ-022 SHALL advance all stages together when adv = !out_valid | out_ready; otherwise every stage holds.
REQ-023 SHALL drive in_ready = adv, combinationally from out_valid and out_ready only, never from in_valid.
REQ-024 SHALL let bubbles (invalid stages) advance like data; they never raise out_valid.
REQ-025 SHALL keep sum stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL deliver results in acceptance order with none dropped or duplicated; at most STAGES tuples are in flight.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear every valid bit, carry register and sum register to 0, so that out_valid = 0 and sum = 0.
REQ-028 SHALL discard in-flight tuples on reset mid-operation; no result appears for them after release.
REQ-029 SHALL drive in_ready = 1 during and after reset, since out_valid = 0.

Structure
REQ-030 SHALL place default WIDTH/STAGES/APPROX_MAX constants, a k-width function and a stage-payload struct typedef in package pipe_add_pkg.
REQ-031 SHALL instantiate sub-module add_seg (combinational SEG-bit segment adder with per-bit approximate mask, carry in/out) once per stage via generate.
REQ-032 SHALL reject at elaboration a WIDTH not divisible by STAGES, or APPROX_MAX > WIDTH.

Verification (WIDTH=16, STAGES=4)
REQ-033 SHALL cover: a=0xFFFF, b=0x0001, k=0 accepted cycle 0 -> out_valid cycle 4, sum=0x10000.
REQ-034 SHALL cover: a=0x000F, b=0x0001, k=4 -> sum=0x0000F; same operands with k=0 -> 0x00010.
REQ-035 SHALL cover: a=0x8000, b=0x8000, approx_k=20 -> saturates to 16, sum=0x08000.
REQ-036 SHALL cover: in_valid held 1, out_ready=0 for 10 cycles -> exactly 4 tuples accepted, in_ready=0 thereafter, sum held; release -> 4 results in order.
REQ-037 SHALL cover: 100 back-to-back random tuples (random k), out_ready=1 -> 100 results, one per cycle, first in cycle 4, matching a reference model.
REQ-038 SHALL cover: rst_n pulsed low with 3 tuples in flight -> out_valid=0 and sum=0 immediately; no stale result afterwards; next tuple latency is 4.
